// File: rtl/lvt_mem_2wnr.sv
// Two-write, N-read memory built from 1w1r bank replicas and a live value table.
// Each read port owns a private copy of both banks; the LVT picks which bank holds the newest value.
module lvt_mem_2wnr #(
  parameter int WIDTH      = 32,
  parameter int ADDR_BITS  = 4,
  parameter int READ_PORTS = 4,
  parameter int BYPASS     = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             we_0,
  input  logic                             we_1,
  input  logic [ADDR_BITS-1:0]             write_addr_0,
  input  logic [ADDR_BITS-1:0]             write_addr_1,
  input  logic [WIDTH-1:0]                 write_data_0,
  input  logic [WIDTH-1:0]                 write_data_1,
  input  logic [READ_PORTS-1:0]            read_en,
  input  logic [READ_PORTS*ADDR_BITS-1:0]  read_addr,
  output logic [READ_PORTS*WIDTH-1:0]      read_data,
  output logic [READ_PORTS-1:0]            read_valid,
  output logic                             write_collision
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DEPTH-1:0] lvt_reg;
  logic             write_collision_reg;
  logic             bank_we_0;
  logic             bank_we_1;
  logic             same_addr_write;

  // Bank writes are suppressed on any edge that sees reset high.
  assign bank_we_0       = we_0 & ~reset;
  assign bank_we_1       = we_1 & ~reset;
  assign same_addr_write = we_0 && we_1 && (write_addr_0 == write_addr_1);

  // Port 1's assignment comes last so it wins a same-address dual write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lvt_reg             <= '0;
      write_collision_reg <= 1'b0;
    end else begin
      if (we_0) lvt_reg[write_addr_0] <= 1'b0;
      if (we_1) lvt_reg[write_addr_1] <= 1'b1;
      write_collision_reg <= same_addr_write;
    end
  end

  assign write_collision = write_collision_reg;

  genvar gi;
  generate
    for (gi = 0; gi < READ_PORTS; gi++) begin : g_port
      logic [WIDTH-1:0]     bank0_mem [DEPTH];
      logic [WIDTH-1:0]     bank1_mem [DEPTH];
      logic [ADDR_BITS-1:0] rd_addr;
      logic [WIDTH-1:0]     stored_data;
      logic [WIDTH-1:0]     rd_next;
      logic [WIDTH-1:0]     read_data_reg;
      logic                 read_valid_reg;

      assign rd_addr = read_addr[gi*ADDR_BITS +: ADDR_BITS];

      always_ff @(posedge clock) begin
        if (bank_we_0) bank0_mem[write_addr_0] <= write_data_0;
      end

      always_ff @(posedge clock) begin
        if (bank_we_1) bank1_mem[write_addr_1] <= write_data_1;
      end

      assign stored_data = lvt_reg[rd_addr] ? bank1_mem[rd_addr] : bank0_mem[rd_addr];

      // Write-first forwarding mirrors the LVT priority: port 1 beats port 0.
      always_comb begin
        rd_next = stored_data;
        if (BYPASS != 0) begin
          if (we_1 && (write_addr_1 == rd_addr)) begin
            rd_next = write_data_1;
          end else if (we_0 && (write_addr_0 == rd_addr)) begin
            rd_next = write_data_0;
          end
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          read_data_reg  <= '0;
          read_valid_reg <= 1'b0;
        end else begin
          read_valid_reg <= read_en[gi];
          if (read_en[gi]) read_data_reg <= rd_next;
        end
      end

      assign read_data[gi*WIDTH +: WIDTH] = read_data_reg;
      assign read_valid[gi]               = read_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_lvt_mem_2wnr.sv
// Directed bench for lvt_mem_2wnr: one write-first and one read-old instance driven in lockstep.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_lvt_mem_2wnr;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         we_0, we_1;
  logic [3:0]   write_addr_0, write_addr_1;
  logic [31:0]  write_data_0, write_data_1;
  logic [3:0]   read_en;
  logic [15:0]  read_addr;
  logic [127:0] rd_byp, rd_old;
  logic [3:0]   rv_byp, rv_old;
  logic         wc_byp, wc_old;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  lvt_mem_2wnr #(.WIDTH(32), .ADDR_BITS(4), .READ_PORTS(4), .BYPASS(1)) dut_byp (
    .clock(clock), .reset(reset), .we_0(we_0), .we_1(we_1),
    .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
    .write_data_0(write_data_0), .write_data_1(write_data_1),
    .read_en(read_en), .read_addr(read_addr),
    .read_data(rd_byp), .read_valid(rv_byp), .write_collision(wc_byp)
  );

  lvt_mem_2wnr #(.WIDTH(32), .ADDR_BITS(4), .READ_PORTS(4), .BYPASS(0)) dut_old (
    .clock(clock), .reset(reset), .we_0(we_0), .we_1(we_1),
    .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
    .write_data_0(write_data_0), .write_data_1(write_data_1),
    .read_en(read_en), .read_addr(read_addr),
    .read_data(rd_old), .read_valid(rv_old), .write_collision(wc_old)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %s ok (%0h)", tag, obs);
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    we_0    = 1'b0;
    we_1    = 1'b0;
    read_en = '0;
  endtask

  task automatic wr0(input logic [3:0] a, input logic [31:0] d);
    we_0 = 1'b1; write_addr_0 = a; write_data_0 = d;
  endtask

  task automatic wr1(input logic [3:0] a, input logic [31:0] d);
    we_1 = 1'b1; write_addr_1 = a; write_data_1 = d;
  endtask

  task automatic rd(input int p, input logic [3:0] a);
    read_en[p] = 1'b1;
    read_addr[p*4 +: 4] = a;
  endtask

  function automatic logic [31:0] port(input logic [127:0] v, input int p);
    return v[p*32 +: 32];
  endfunction

  initial begin
    we_0 = 0; we_1 = 0; write_addr_0 = 0; write_addr_1 = 0;
    write_data_0 = 0; write_data_1 = 0; read_en = 0; read_addr = 0;

    // Reset state
    tick(); tick();
    chk("reset rd_byp", rd_byp, 128'h0);
    chk("reset rd_old", rd_old, 128'h0);
    chk("reset rv_byp", rv_byp, 4'h0);
    chk("reset wc_byp", wc_byp, 1'b0);
    reset = 1'b0;

    // Basic write then read, latency 1
    wr0(4'd3, 32'h11111111);
    tick(); clr();
    chk("no valid after write", rv_byp, 4'h0);
    rd(0, 4'd3);
    tick(); clr();
    chk("basic rd byp", port(rd_byp, 0), 32'h11111111);
    chk("basic rd old", port(rd_old, 0), 32'h11111111);
    chk("basic valid", rv_byp, 4'b0001);
    tick();
    chk("valid drops", rv_byp, 4'h0);
    chk("data held idle", port(rd_byp, 0), 32'h11111111);

    // Later write through port 1 overrides via LVT; all ports read same address
    wr0(4'd5, 32'hAAAA0000);
    tick(); clr();
    wr1(4'd5, 32'h0000BBBB);
    tick(); clr();
    for (int p = 0; p < 4; p++) rd(p, 4'd5);
    tick(); clr();
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("lvt all ports byp p%0d", p), port(rd_byp, p), 32'h0000BBBB);
      chk($sformatf("lvt all ports old p%0d", p), port(rd_old, p), 32'h0000BBBB);
    end
    chk("all valid", rv_old, 4'hF);

    // Same-address dual write: collision pulse, port 1 wins
    wr0(4'd7, 32'h1);
    wr1(4'd7, 32'h2);
    tick(); clr();
    chk("collision pulse byp", wc_byp, 1'b1);
    chk("collision pulse old", wc_old, 1'b1);
    rd(1, 4'd7);
    tick(); clr();
    chk("collision clears", wc_byp, 1'b0);
    chk("collision winner byp", port(rd_byp, 1), 32'h2);
    chk("collision winner old", port(rd_old, 1), 32'h2);

    // Dual write to distinct addresses is not a collision
    wr0(4'd6, 32'h66);
    wr1(4'd8, 32'h88);
    tick(); clr();
    chk("no collision distinct", wc_byp, 1'b0);
    rd(0, 4'd6); rd(1, 4'd8);
    tick(); clr();
    chk("distinct w0", port(rd_byp, 0), 32'h66);
    chk("distinct w1", port(rd_byp, 1), 32'h88);

    // Same-edge read/write: write-first vs read-old
    wr0(4'd9, 32'h5);
    tick(); clr();
    wr0(4'd9, 32'h6);
    rd(3, 4'd9);
    tick(); clr();
    chk("bypass new", port(rd_byp, 3), 32'h6);
    chk("readold old", port(rd_old, 3), 32'h5);
    rd(3, 4'd9);
    tick(); clr();
    chk("next read byp", port(rd_byp, 3), 32'h6);
    chk("next read old", port(rd_old, 3), 32'h6);

    // Forwarding priority when both writers hit the read address
    wr0(4'd10, 32'h100);
    wr1(4'd10, 32'h200);
    rd(2, 4'd10);
    tick(); clr();
    chk("bypass port1 prio", port(rd_byp, 2), 32'h200);
    rd(2, 4'd10);
    tick(); clr();
    chk("old after dual", port(rd_old, 2), 32'h200);

    // Address extremes
    wr1(4'd15, 32'hF);
    wr0(4'd0, 32'hA0);
    tick(); clr();
    rd(0, 4'd15); rd(1, 4'd0);
    tick(); clr();
    chk("addr 15", port(rd_byp, 0), 32'hF);
    chk("addr 0", port(rd_old, 1), 32'hA0);

    // Four ports, four different addresses
    rd(0, 4'd3); rd(1, 4'd5); rd(2, 4'd7); rd(3, 4'd9);
    tick(); clr();
    chk("multi byp", rd_byp, {32'h6, 32'h2, 32'h0000BBBB, 32'h11111111});
    chk("multi old", rd_old, {32'h6, 32'h2, 32'h0000BBBB, 32'h11111111});

    // Hold with read_en low while the address is rewritten
    wr0(4'd4, 32'hE);
    tick(); clr();
    rd(2, 4'd4);
    tick(); clr();
    chk("hold base", port(rd_byp, 2), 32'hE);
    wr0(4'd4, 32'h77);
    tick(); clr();
    chk("hold after w0", port(rd_byp, 2), 32'hE);
    chk("hold valid low", rv_byp[2], 1'b0);
    wr1(4'd4, 32'h88);
    tick(); clr();
    chk("hold after w1", port(rd_old, 2), 32'hE);

    // Mid-cycle reset during a port-1 write and a read request
    wr1(4'd2, 32'hC);
    rd(0, 4'd3);
    #3 reset = 1'b1;
    #1;
    chk("async rst rd_byp", rd_byp, 128'h0);
    chk("async rst rd_old", rd_old, 128'h0);
    chk("async rst rv", rv_byp, 4'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    clr();
    chk("read ignored in rst", rd_byp, 128'h0);
    wr0(4'd2, 32'hD);
    tick(); clr();
    rd(0, 4'd2); rd(1, 4'd5);
    tick(); clr();
    chk("post rst w0 byp", port(rd_byp, 0), 32'hD);
    chk("post rst w0 old", port(rd_old, 0), 32'hD);
    chk("lvt cleared byp", port(rd_byp, 1), 32'hAAAA0000);
    chk("lvt cleared old", port(rd_old, 1), 32'hAAAA0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
